regfile_dump: RTL and testbench
===============================

Name: regfile_dump

Overview:
- Debug read-out engine. On a start pulse it walks a contiguous register range through a spare register-file read port and serializes the contents as a byte stream.
- Output uses a valid/ready handshake toward the UART/debug transmitter.
- Sits beside the CPU register file as the reader of what writeback stores.
- Frame format: header byte, then 4 bytes per register, MSB first, then an XOR checksum byte.

Parameters:
- FIRST_REG, 0, first register index dumped (0..31)
- LAST_REG, 31, last register index dumped (FIRST_REG..31)
- HEADER, 8'hA5, frame start byte

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a dump
- rd_addr  output  5  register-file read address
- rd_data  input  32  register-file read data, combinational from rd_addr
- tx_data  output  8  stream byte
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  consumer accepts the byte this cycle
- busy  output  1  dump in progress
- done  output  1  one-cycle pulse after the checksum byte is accepted

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset. All state updates on posedge clk.
- Reset values: state=IDLE, tx_valid=0, tx_data=0, busy=0, done=0, rd_addr=FIRST_REG, index=FIRST_REG, checksum=0.
- Reset asserted mid-frame aborts the frame immediately. The next cycle shows IDLE and tx_valid=0, and no done pulse is produced.
- FSM states: IDLE, HDR, LOAD, SEND, TAIL.
- IDLE: busy=0. When start=1, go to HDR, set index=FIRST_REG, clear checksum. The header is valid the cycle after start.
- HDR: tx_valid=1, tx_data=HEADER. On tx_ready, go to LOAD.
- LOAD: tx_valid=0, rd_addr=index. Capture rd_data into a 32-bit shift register, set byte count=3, go to SEND. Exactly one bubble cycle per register.
- SEND: tx_valid=1, tx_data=shift[31:24].
  - On tx_ready: checksum ^= byte, shift <<= 8, count decrements.
  - When the count=0 byte is accepted: if index==LAST_REG go to TAIL, else increment index and go to LOAD.
- TAIL: tx_valid=1, tx_data=checksum. On tx_ready, go to IDLE and pulse done=1 for exactly one cycle.
- Handshake rules:
  - A byte transfers only in a cycle with tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - tx_valid never drops before acceptance.
  - tx_ready while tx_valid=0 is ignored.
- start is ignored while busy=1, including in the cycle done is asserted. busy=1 in every state except IDLE.
- Checksum covers register data bytes only; the header is excluded.
- Index wrap: LAST_REG=31 is handled with no 5-bit overflow, since the index compare happens before increment.
- Register $0 is dumped as whatever rd_data returns (the register file forces 0).
- Frame length = 2 + 4*(LAST_REG-FIRST_REG+1) bytes: 130 for the defaults.
- Minimum frame time with tx_ready held at 1: 1 (HDR) + 5 per register + 1 (TAIL) cycles.

Decomposition:
- Shared debug package holds:
  - state encoding typedef (IDLE/HDR/LOAD/SEND/TAIL)
  - HEADER default constant
  - REG_ADDR_W=5 and REG_COUNT=32 constants, shared with the register file
- No sub-module needed.
- The byte shifter plus checksum accumulator is kept inline; splitting it out is not warranted at this size.

Test Plan:
- Register file freshly reset ($29=0x00000400, $31=0x0040000C, all others 0), defaults, tx_ready=1 constantly, pulse start.
  - Required: 130 bytes: A5; 0x00 for regs 0..28; 00 00 04 00; 00 00 00 00; 00 40 00 0C; checksum 0x48.
  - done pulses one cycle after the final transfer; busy falls with it.
- FIRST_REG=29, LAST_REG=31, same register contents.
  - Required: A5 00 00 04 00 00 00 00 00 00 40 00 0C 48, 14 bytes, total 17 cycles from header-valid to done.
- Backpressure: tx_ready toggles pseudo-randomly, and is held low 5 cycles while byte 0x04 is presented.
  - Required: tx_data holds 0x04 with tx_valid=1 throughout, no byte dropped or duplicated, checksum still 0x48.
- Pulse start again during SEND and in the done cycle.
  - Required: ignored, with exactly one frame produced. A start after done returns to IDLE begins a new frame with header A5.
- Assert reset for one cycle during SEND of register 15.
  - Required: next cycle tx_valid=0, busy=0, no done pulse.
  - A subsequent start yields a complete correct frame whose checksum is unaffected by the aborted one.
- Write $5=0xDEADBEEF via writeback, then dump with FIRST_REG=LAST_REG=5.
  - Required: A5 DE AD BE EF, then checksum DE^AD^BE^EF=0x22.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared debug package: FSM state encoding and register-file geometry
// constants used by the dump engine and the CPU register file.
package regfile_dump_pkg;

   localparam int         REG_ADDR_W     = 5;
   localparam int         REG_COUNT      = 32;
   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_LOAD,
      ST_SEND,
      ST_TAIL
   } state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// Byte stream toward the UART/debug transmitter: valid/ready handshake.
// master = byte source (dump engine), slave = byte sink (transmitter).
interface regfile_dump_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/regfile_dump.sv
// Debug read-out engine. On start, walks registers FIRST_REG..LAST_REG through
// a spare register-file read port and emits: header, 4 bytes per register
// (MSB first), then the XOR of all register bytes.
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31,
   parameter logic [7:0]  HEADER    = HEADER_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [31:0]           rd_data,
   regfile_dump_if.master        tx,
   output logic                  busy,
   output logic                  done
);

   localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
   localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

   state_e                  state_q,    state_d;
   logic [REG_ADDR_W-1:0]   index_q,    index_d;
   logic [31:0]             shift_q,    shift_d;
   logic [1:0]              count_q,    count_d;
   logic [7:0]              checksum_q, checksum_d;
   logic                    done_q,     done_d;

   // State register and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every register updates from its pre-edge value.
      if (reset) begin
         state_q    <= ST_IDLE;
         index_q    <= FIRST_IDX;
         shift_q    <= '0;
         count_q    <= '0;
         checksum_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         shift_q    <= shift_d;
         count_q    <= count_d;
         checksum_q <= checksum_d;
         done_q     <= done_d;
      end
   end

   // Next-state and stream outputs; index is compared before it is
   // incremented so LAST_REG=31 never needs a sixth address bit.
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      state_d     = state_q;
      index_d     = index_q;
      shift_d     = shift_q;
      count_d     = count_q;
      checksum_d  = checksum_q;
      done_d      = 1'b0;
      tx.tx_valid = 1'b0;
      tx.tx_data  = '0;

      unique case (state_q)
         ST_IDLE: begin
            // The done cycle still counts as part of the dump for start.
            if (start && !done_q) begin
               state_d    = ST_HDR;
               index_d    = FIRST_IDX;
               checksum_d = '0;
            end
         end
         ST_HDR: begin
            tx.tx_valid = 1'b1;
            tx.tx_data  = HEADER;
            if (tx.tx_ready) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            // Single bubble cycle: rd_data is valid for rd_addr=index now.
            shift_d = rd_data;
            count_d = 2'd3;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            tx.tx_valid = 1'b1;
            tx.tx_data  = shift_q[31:24];
            if (tx.tx_ready) begin
               checksum_d = checksum_q ^ shift_q[31:24];
               shift_d    = {shift_q[23:0], 8'h00};
               count_d    = count_q - 2'd1;
               if (count_q == 2'd0) begin
                  if (index_q == LAST_IDX) begin
                     state_d = ST_TAIL;
                  end else begin
                     index_d = index_q + REG_ADDR_W'(1);
                     state_d = ST_LOAD;
                  end
               end
            end
         end
         ST_TAIL: begin
            tx.tx_valid = 1'b1;
            tx.tx_data  = checksum_q;
            if (tx.tx_ready) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rd_addr = index_q;
   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: three instances (full range, 29..31,
// single register 5) sharing one register-file model; the expected frame is
// built directly from the register array with plain loops.
module tb_regfile_dump;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  start_v;
   logic [2:0]  ready_v;
   logic [31:0] regs [32];

   logic [4:0]  rd_addr0, rd_addr1, rd_addr2;
   logic [31:0] rd_data0, rd_data1, rd_data2;
   logic        busy0, busy1, busy2;
   logic        done0, done1, done2;

   int          tests = 0;
   int          fails = 0;
   int          sel   = 0;

   logic        cur_valid, cur_busy, cur_done;
   logic [7:0]  cur_data;

   logic [7:0]  exp_q [$];
   logic [7:0]  got_q [$];

   always #5 clk = ~clk;

   regfile_dump_if if0 ();
   regfile_dump_if if1 ();
   regfile_dump_if if2 ();

   assign if0.tx_ready = ready_v[0];
   assign if1.tx_ready = ready_v[1];
   assign if2.tx_ready = ready_v[2];

   // Register file read ports: combinational from the address.
   assign rd_data0 = regs[rd_addr0];
   assign rd_data1 = regs[rd_addr1];
   assign rd_data2 = regs[rd_addr2];

   regfile_dump u0 (
      .clk(clk), .reset(reset), .start(start_v[0]), .rd_addr(rd_addr0),
      .rd_data(rd_data0), .tx(if0), .busy(busy0), .done(done0)
   );

   regfile_dump #(.FIRST_REG(29), .LAST_REG(31)) u1 (
      .clk(clk), .reset(reset), .start(start_v[1]), .rd_addr(rd_addr1),
      .rd_data(rd_data1), .tx(if1), .busy(busy1), .done(done1)
   );

   regfile_dump #(.FIRST_REG(5), .LAST_REG(5)) u2 (
      .clk(clk), .reset(reset), .start(start_v[2]), .rd_addr(rd_addr2),
      .rd_data(rd_data2), .tx(if2), .busy(busy2), .done(done2)
   );

   // Select the instance under observation.
   always_comb begin
      cur_valid = 1'b0;
      cur_data  = '0;
      cur_busy  = 1'b0;
      cur_done  = 1'b0;
      case (sel)
         0: begin cur_valid = if0.tx_valid; cur_data = if0.tx_data; cur_busy = busy0; cur_done = done0; end
         1: begin cur_valid = if1.tx_valid; cur_data = if1.tx_data; cur_busy = busy1; cur_done = done1; end
         2: begin cur_valid = if2.tx_valid; cur_data = if2.tx_data; cur_busy = busy2; cur_done = done2; end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected frame from the register contents: header, bytes MSB first, XOR.
   task automatic build_expected(input int first, input int last);
      logic [7:0] x;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      x = 8'h00;
      for (int i = first; i <= last; i++) begin
         for (int k = 3; k >= 0; k--) begin
            exp_q.push_back(regs[i][8*k +: 8]);
            x ^= regs[i][8*k +: 8];
         end
      end
      exp_q.push_back(x);
   endtask

   // mode 0: ready held high; 1: random ready plus a 5-cycle stall on 0x04;
   // 2: ready high, extra start pulses in SEND and in the done cycle;
   // 3: reset pulse while register 15 is being sent (default range only).
   task automatic run_frame(input int s, input int first, input int last,
                            input int mode, output int cycles);
      logic       v, dn, r, prev_v, prev_r;
      logic [7:0] d, prev_d;
      int         stall;
      bit         stalled, pulsed, finished, seen_done;

      build_expected(first, last);
      got_q.delete();
      sel      = s;
      cycles   = -1;
      prev_v   = 1'b0;
      prev_r   = 1'b0;
      prev_d   = '0;
      stall    = 0;
      stalled  = 1'b0;
      pulsed   = 1'b0;
      finished = 1'b0;

      start_v[s] = 1'b1;
      @(negedge clk);
      start_v[s] = 1'b0;
      check($sformatf("busy_at_header_%0d", s), cur_busy, 1);

      for (int cyc = 0; cyc < 2000; cyc++) begin
         v  = cur_valid;
         d  = cur_data;
         dn = cur_done;
         if (dn) begin
            cycles   = cyc;
            finished = 1'b1;
            break;
         end
         if (prev_v && !prev_r) begin
            check("hold_valid", v, 1);
            check("hold_data", d, prev_d);
         end
         r = 1'b1;
         if (mode == 1) begin
            r = 1'($urandom_range(0, 1));
            if (v && d == 8'h04 && !stalled) begin
               if (stall < 5) begin
                  r = 1'b0;
                  stall++;
               end else begin
                  r = 1'b1;
                  stalled = 1'b1;
               end
            end
         end
         if (mode == 2 && got_q.size() == 10 && !pulsed) begin
            start_v[s] = 1'b1;
            pulsed     = 1'b1;
         end else begin
            start_v[s] = 1'b0;
         end
         if (mode == 3 && v && got_q.size() == 62) begin
            reset      = 1'b1;
            ready_v[s] = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            check("abort_valid", cur_valid, 0);
            check("abort_busy", cur_busy, 0);
            check("abort_done", cur_done, 0);
            finished = 1'b1;
            break;
         end
         ready_v[s] = r;
         if (v && r) got_q.push_back(d);
         prev_v = v;
         prev_r = r;
         prev_d = d;
         @(negedge clk);
      end
      ready_v[s] = 1'b0;
      start_v[s] = 1'b0;
      check($sformatf("frame_finished_mode%0d", mode), finished, 1);

      if (mode == 3) begin
         seen_done = 1'b0;
         repeat (20) begin
            @(negedge clk);
            if (cur_done || cur_valid) seen_done = 1'b1;
         end
         check("abort_no_done", seen_done, 0);
      end else begin
         check("busy_in_done", cur_busy, 0);
         if (mode == 2) start_v[s] = 1'b1;
         @(negedge clk);
         start_v[s] = 1'b0;
         check("done_one_cycle", cur_done, 0);
         check("idle_valid_after", cur_valid, 0);
         check("idle_busy_after", cur_busy, 0);
         check("frame_length", got_q.size(), exp_q.size());
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("byte_%0d", i), got_q[i], exp_q[i]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cycles;
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      regs[29] = 32'h0000_0400;
      regs[31] = 32'h0040_000C;
      start_v  = '0;
      ready_v  = '0;
      reset    = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state.
      check("rst_valid", if0.tx_valid, 0);
      check("rst_data", if0.tx_data, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_addr0", rd_addr0, 0);
      check("rst_addr1", rd_addr1, 29);
      check("rst_addr2", rd_addr2, 5);

      // Full default frame with tx_ready held high.
      run_frame(0, 0, 31, 0, cycles);
      check("default_cycles", cycles, 162);
      if (got_q.size() == 130) check("default_checksum", got_q[129], 8'h48);

      // Narrow range 29..31.
      run_frame(1, 29, 31, 0, cycles);
      check("narrow_cycles", cycles, 17);

      // Backpressure, stall on 0x04.
      run_frame(0, 0, 31, 1, cycles);
      if (got_q.size() == 130) check("bp_checksum", got_q[129], 8'h48);

      // Spurious starts in SEND and done cycle, then immediate restart.
      run_frame(0, 0, 31, 2, cycles);
      run_frame(0, 0, 31, 0, cycles);

      // Abort by reset, then a clean frame.
      run_frame(0, 0, 31, 3, cycles);
      run_frame(0, 0, 31, 0, cycles);
      if (got_q.size() == 130) check("post_abort_checksum", got_q[129], 8'h48);

      // Writeback of $5, single-register dump.
      regs[5] = 32'hDEAD_BEEF;
      run_frame(2, 5, 5, 0, cycles);
      if (got_q.size() == 6) check("deadbeef_checksum", got_q[5], 8'h22);

      // Random register contents ($0 stays zero) under random backpressure.
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      run_frame(0, 0, 31, 1, cycles);
      run_frame(1, 29, 31, 1, cycles);
      run_frame(2, 5, 5, 1, cycles);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
